// File: rtl/int_responder_pkg.sv
// Shared definitions for the Z80 IM2 interrupt responder: sequencer state
// encoding, RETI opcode bytes, default source count and a priority helper.
package int_responder_pkg;

    localparam int DEFAULT_NUM_SRC = 4;

    // RETI is the two-byte opcode ED 4D.
    localparam logic [7:0] RETI_OP1 = 8'hED;
    localparam logic [7:0] RETI_OP2 = 8'h4D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Index of the lowest set request bit (lowest index has highest priority).
    function automatic logic [1:0] lowest_set(input logic [3:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_responder_sync2.sv
// Two-flop synchronizer for signals arriving asynchronously to clk.
// Clears to zero on reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/int_responder.sv
// Z80 mode-2 interrupt responder. Collects edge-triggered requests from
// NUM_SRC sources, raises INT for the highest-priority one and places its
// vector on the data bus during the CPU's interrupt acknowledge cycle.
// Optional feature macro: RETI_DETECT_EN -- keeps the in-service flag set
// until the CPU fetches a RETI (ED 4D) and blocks new requests meanwhile.
module int_responder
    import int_responder_pkg::*;
#(
    parameter int NUM_SRC   = DEFAULT_NUM_SRC,
    parameter int VEC_ALIGN = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    inout  wire  [7:0]         data,
    input  logic               m1_n,
    input  logic               iorq_n,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [7:0]         vector_base,
    output logic               int_n,
    output logic [NUM_SRC-1:0] in_service
);

    // Vector bits below VEC_ALIGN come from the block, the rest from vector_base.
    localparam logic [7:0] LOW_MASK = 8'((1 << VEC_ALIGN) - 1);

    logic               m1_sync;
    logic               iorq_sync;
    logic [NUM_SRC-1:0] src_sync;
    logic [NUM_SRC-1:0] src_prev_reg;
    logic [NUM_SRC-1:0] src_rise;
    logic [NUM_SRC-1:0] pending_reg;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] pending_eff;
    logic [NUM_SRC-1:0] in_service_reg;
    logic [NUM_SRC-1:0] in_service_next;
    logic [NUM_SRC-1:0] ack_clr;
    state_t             state_reg;
    state_t             state_next;
    logic [1:0]         winner_reg;
    logic [1:0]         winner_calc;
    logic [7:0]         vector_reg;
    logic [7:0]         vector_calc;
    logic               intack_sync;
    logic               service_block;
    logic               service_release;
    logic               take_req;
    logic               take_ack;
    logic               hold_done;
    logic               drive_en;

    sync2 #(.WIDTH(1)) u_sync_m1 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (m1_n),
        .q       (m1_sync)
    );

    sync2 #(.WIDTH(1)) u_sync_iorq (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (iorq_n),
        .q       (iorq_sync)
    );

    sync2 #(.WIDTH(NUM_SRC)) u_sync_src (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (src_req),
        .q       (src_sync)
    );

    assign intack_sync = !m1_sync && !iorq_sync;

    // A fresh edge counts as pending this cycle so a request can be taken
    // without waiting for pending_reg to catch up.
    assign pending_eff = pending_reg | src_rise;
    assign winner_calc = lowest_set(pending_eff);
    assign vector_calc = (vector_base & ~LOW_MASK) | {5'b0, winner_calc, 1'b0};

`ifdef RETI_DETECT_EN
    logic m1_prev_reg;
    logic ed_seen_reg;
    logic fetch_strobe;

    // One strobe per opcode fetch: synchronized M1 falls while IORQ is idle.
    assign fetch_strobe    = !m1_sync && m1_prev_reg && iorq_sync;
    assign service_release = fetch_strobe && ed_seen_reg && (data == RETI_OP2);
    assign service_block   = |in_service_reg;

    // Watch the fetched opcode stream for ED immediately followed by 4D.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m1_prev_reg <= 1'b0;
            ed_seen_reg <= 1'b0;
        end else begin
            m1_prev_reg <= m1_sync;
            if (fetch_strobe) begin
                ed_seen_reg <= (data == RETI_OP1);
            end
        end
    end
`else
    // Service ends as soon as the acknowledge cycle is over.
    assign service_release = hold_done;
    assign service_block   = 1'b0;
`endif

    // Per-source edge detect, pending (set wins over clear) and in-service flags.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_rise[gi]        = src_sync[gi] & ~src_prev_reg[gi];
        assign ack_clr[gi]         = take_ack && (winner_reg == 2'(gi));
        assign pending_next[gi]    = src_rise[gi] | (pending_reg[gi] & ~ack_clr[gi]);
        assign in_service_next[gi] = ack_clr[gi] | (in_service_reg[gi] & ~service_release);
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sequencer next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (take_req)  state_next = ST_REQ;
            ST_REQ:  if (take_ack)  state_next = ST_ACK;
            ST_ACK:                 state_next = ST_HOLD;
            ST_HOLD: if (hold_done) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Sequencer outputs; bus drive uses the raw strobes so the vector appears
    // as soon as the CPU opens the acknowledge cycle.
    always_comb begin
        int_n     = 1'b1;
        take_req  = 1'b0;
        take_ack  = 1'b0;
        hold_done = 1'b0;
        drive_en  = 1'b0;
        case (state_reg)
            ST_IDLE: take_req = (|pending_eff) && !service_block;
            ST_REQ: begin
                int_n    = 1'b0;
                take_ack = intack_sync;
                drive_en = !m1_n && !iorq_n;
            end
            ST_ACK:  drive_en  = !m1_n && !iorq_n;
            ST_HOLD: hold_done = iorq_sync;
            default: ;
        endcase
    end

    assign data = drive_en ? vector_reg : {8{1'bz}};

    // Request bookkeeping; winner and vector are frozen once a request is raised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_prev_reg   <= '0;
            pending_reg    <= '0;
            in_service_reg <= '0;
            winner_reg     <= 2'd0;
            vector_reg     <= 8'h00;
        end else begin
            src_prev_reg   <= src_sync;
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
            if (take_req) begin
                winner_reg <= winner_calc;
                vector_reg <= vector_calc;
            end
        end
    end

    assign in_service = in_service_reg;

endmodule

// File: tb/tb_int_responder.sv
// Testbench for int_responder: directed acknowledge scenarios with literal
// expectations plus a randomized CPU/source run checked every cycle against
// a behavioural model. Build with RETI_DETECT_EN to exercise RETI handling.
module tb_int_responder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m1_n = 1'b1;
    logic       iorq_n = 1'b1;
    logic [3:0] src_req = 4'b0000;
    logic [7:0] vector_base = 8'h40;
    logic       int_n;
    logic [3:0] in_service;
    wire  [7:0] data;

    logic       tb_data_en = 1'b0;
    logic [7:0] tb_data_drv = 8'h00;

    // Undriven bus floats to FF through pull-ups; a vector always has bit 0 low.
    localparam logic [7:0] BUS_IDLE = 8'hFF;

    assign data = tb_data_en ? tb_data_drv : {8{1'bz}};

    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
        pullup pu (data[gi]);
    end

    int_responder #(.NUM_SRC(4), .VEC_ALIGN(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data        (data),
        .m1_n        (m1_n),
        .iorq_n      (iorq_n),
        .src_req     (src_req),
        .vector_base (vector_base),
        .int_n       (int_n),
        .in_service  (in_service)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases of one interrupt transaction as seen from outside.
    localparam int PH_WAIT    = 0;  // nothing being signalled
    localparam int PH_ASSERT  = 1;  // INT low, waiting for the CPU
    localparam int PH_ACKED   = 2;  // acknowledge recognised this cycle
    localparam int PH_RELEASE = 3;  // waiting for IORQ to go away

    int         m_phase;
    logic [3:0] m_pend;
    logic [3:0] m_isv;
    logic [7:0] m_vec;
    int         m_w;
    bit         m_seen;
    // Raw input samples at previous clock edges: [0] = last edge, [1] = two ago ...
    logic [2:0] m1_h;
    logic [2:0] iorq_h;
    logic [3:0] src_h [0:2];

    task automatic model_reset();
        m_phase = PH_WAIT;
        m_pend  = 4'b0;
        m_isv   = 4'b0;
        m_vec   = 8'h00;
        m_w     = 0;
        m_seen  = 1'b0;
        m1_h    = 3'b0;
        iorq_h  = 3'b0;
        for (int i = 0; i < 3; i++) src_h[i] = 4'b0;
    endtask

    task automatic model_step();
        logic       s_m1;
        logic       s_iorq;
        logic [3:0] rise;
        logic [3:0] avail;
        logic [3:0] lowbit;
        logic [1:0] wb;
        bit         fetch;
        // Inputs become visible to the block two edges after they are sampled.
        s_m1   = m1_h[1];
        s_iorq = iorq_h[1];
        rise   = src_h[1] & ~src_h[2];
        avail  = m_pend | rise;
        fetch  = !m1_h[1] && m1_h[2] && iorq_h[1];
        case (m_phase)
            PH_WAIT: begin
`ifdef RETI_DETECT_EN
                if (avail != 0 && m_isv == 0) begin
`else
                if (avail != 0) begin
`endif
                    lowbit  = avail & (~avail + 4'd1);
                    m_w     = $clog2(lowbit);
                    wb      = 2'(m_w);
                    m_vec   = {vector_base[7:3], wb, 1'b0};
                    m_phase = PH_ASSERT;
                end
            end
            PH_ASSERT: begin
                if (!s_m1 && !s_iorq) begin
                    m_pend[m_w] = 1'b0;
                    m_isv[m_w]  = 1'b1;
                    m_phase     = PH_ACKED;
                end
            end
            PH_ACKED: m_phase = PH_RELEASE;
            default: begin
                if (s_iorq) begin
                    m_phase = PH_WAIT;
`ifndef RETI_DETECT_EN
                    m_isv = 4'b0;
`endif
                end
            end
        endcase
        m_pend = m_pend | rise;
`ifdef RETI_DETECT_EN
        if (fetch) begin
            if (data == 8'hED) begin
                m_seen = 1'b1;
            end else begin
                if (m_seen && data == 8'h4D) m_isv = 4'b0;
                m_seen = 1'b0;
            end
        end
`else
        if (fetch) m_seen = 1'b0;
`endif
        m1_h   = {m1_h[1:0], m1_n};
        iorq_h = {iorq_h[1:0], iorq_n};
        src_h[2] = src_h[1];
        src_h[1] = src_h[0];
        src_h[0] = src_req;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // Compare process: every falling edge, outputs against the model.
    initial begin
        logic [7:0] exp_data;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                if (tb_data_en)
                    exp_data = tb_data_drv;
                else if ((m_phase == PH_ASSERT || m_phase == PH_ACKED) && !m1_n && !iorq_n)
                    exp_data = m_vec;
                else
                    exp_data = BUS_IDLE;
                chk("model_int_n", int_n, (m_phase == PH_ASSERT) ? 1'b0 : 1'b1);
                chk("model_in_service", in_service, m_isv);
                chk("model_data", data, exp_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_int_low(input string name, input int max_edges);
        int n = 0;
        while (int_n !== 1'b0 && n < max_edges) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, int_n, 1'b0);
    endtask

    task automatic intack(output logic [7:0] vec, output logic [3:0] isv);
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        #1 vec = data;
        #1;
        tick(4);
        isv    = in_service;
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        tick(3);
        $display("[TB] intack vector=%02h in_service=%b", vec, isv);
    endtask

    task automatic fetch(input logic [7:0] b);
        m1_n        = 1'b0;
        iorq_n      = 1'b1;
        tb_data_drv = b;
        tb_data_en  = 1'b1;
        tick(4);
        m1_n       = 1'b1;
        tb_data_en = 1'b0;
        tick(3);
        $display("[TB] fetch opcode=%02h in_service=%b", b, in_service);
    endtask

    task automatic reti();
        fetch(8'hED);
        fetch(8'h4D);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] vec;
        logic [3:0] isv;
        int busy;
        int gap;

        tick(2);
        chk("reset_int_n", int_n, 1'b1);
        chk("reset_in_service", in_service, 4'b0000);
        chk("reset_data", data, BUS_IDLE);
        cmp_en  = 1'b1;
        reset_n = 1'b1;
        tick(4);

        // Single source, vector 0x44.
        vector_base = 8'h40;
        src_req     = 4'b0100;
        wait_int_low("src2_int_within_3", 3);
        intack(vec, isv);
        chk("src2_vector", vec, 8'h44);
        chk("src2_in_service", isv, 4'b0100);
        src_req = 4'b0000;
        tick(2);
`ifdef RETI_DETECT_EN
        chk("src2_in_service_held", in_service, 4'b0100);
        reti();
        chk("src2_reti_cleared", in_service, 4'b0000);

        // Source 0 in service blocks source 1 until RETI.
        src_req = 4'b0001;
        wait_int_low("src0_int", 4);
        intack(vec, isv);
        chk("src0_vector", vec, 8'h40);
        src_req = 4'b0010;
        tick(8);
        chk("blocked_int_n", int_n, 1'b1);
        chk("blocked_in_service", in_service, 4'b0001);
        reti();
        wait_int_low("after_reti_int", 6);
        intack(vec, isv);
        chk("after_reti_vector", vec, 8'h42);
        chk("after_reti_in_service", isv, 4'b0010);
        src_req = 4'b0000;

        // Broken RETI sequence must not release service.
        fetch(8'hED);
        fetch(8'h00);
        fetch(8'h4D);
        chk("broken_reti_in_service", in_service, 4'b0010);
        reti();
        chk("reti_final_clear", in_service, 4'b0000);
`else
        chk("src2_in_service_cleared", in_service, 4'b0000);

        // Two sources together: lower index first, then the other.
        src_req = 4'b1010;
        wait_int_low("dual_first_int", 4);
        intack(vec, isv);
        chk("dual_first_vector", vec, 8'h42);
        src_req = 4'b0000;
        wait_int_low("dual_second_int", 6);
        intack(vec, isv);
        chk("dual_second_vector", vec, 8'h46);
        chk("dual_second_in_service", isv, 4'b1000);
`endif

        // Opcode fetch while INT is asserted leaves the bus alone.
        tick(2);
        src_req = 4'b0001;
        wait_int_low("fetch_in_req_int", 4);
        m1_n   = 1'b0;
        iorq_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fetch_in_req_data", data, BUS_IDLE);
            chk("fetch_in_req_int_n", int_n, 1'b0);
            tick(1);
        end
        m1_n = 1'b1;
        tick(2);
        intack(vec, isv);
        chk("fetch_in_req_vector", vec, 8'h40);
        src_req = 4'b0000;
`ifdef RETI_DETECT_EN
        reti();
`endif
        tick(2);

        // Reset in the middle of an acknowledge cycle.
        src_req = 4'b0010;
        wait_int_low("rst_ack_int", 4);
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        #1;
        chk("rst_ack_data_before", data, 8'h42);
        tick(1);
        reset_n = 1'b0;
        #1;
        chk("rst_ack_data_z", data, BUS_IDLE);
        chk("rst_ack_int_n", int_n, 1'b1);
        chk("rst_ack_in_service", in_service, 4'b0000);
        src_req = 4'b0000;
        m1_n    = 1'b1;
        iorq_n  = 1'b1;
        tick(1);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            #1;
            chk("rst_release_int_n", int_n, 1'b1);
            #1;
        end
        chk("rst_release_in_service", in_service, 4'b0000);

        // Randomized sources, acknowledges and fetches against the model.
        busy = 0;
        gap  = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) src_req[i] = ~src_req[i];
            end
            if ($urandom_range(0, 15) == 0) vector_base = 8'($urandom);
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    m1_n       = 1'b1;
                    iorq_n     = 1'b1;
                    tb_data_en = 1'b0;
                    gap        = $urandom_range(2, 4);
                end
            end else if (gap > 0) begin
                gap--;
            end else if (int_n == 1'b0 && $urandom_range(0, 2) == 0) begin
                m1_n   = 1'b0;
                iorq_n = 1'b0;
                busy   = $urandom_range(3, 6);
                $display("[TB] random intack at cycle %0d", c);
            end else if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 4))
                    0, 1:    tb_data_drv = 8'hED;
                    2, 3:    tb_data_drv = 8'h4D;
                    default: tb_data_drv = 8'($urandom);
                endcase
                m1_n       = 1'b0;
                iorq_n     = 1'b1;
                tb_data_en = 1'b1;
                busy       = $urandom_range(3, 5);
                $display("[TB] random fetch opcode=%02h at cycle %0d", tb_data_drv, c);
            end
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_responder.md
INT_RESPONDER -- requirements
Module: int_responder

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, the number of interrupt sources (fixed 4 in this revision).
REQ-002 SHALL have parameter VEC_ALIGN, default 3, the number of low vector bits supplied by the block.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 data  inout  8  Z80 data bus; the block drives it only during its own acknowledge cycle.
REQ-006 m1_n  input  1  Z80 M1 strobe; asynchronous to clk.
REQ-007 iorq_n  input  1  Z80 IORQ strobe; asynchronous to clk.
REQ-008 src_req  input  NUM_SRC  per-source request lines; a rising edge raises a request.
REQ-009 vector_base  input  8  IM2 vector base from the control register; bits [7:3] are used.
REQ-010 int_n  output  1  Z80 INT request; active-low.
REQ-011 in_service  output  NUM_SRC  one-hot flag of the source currently being serviced.

Function
REQ-012 m1_n, iorq_n and src_req SHALL each pass through a 2-flop synchronizer before any use by the state machine.
REQ-013 A synchronized rising edge on src_req[i] SHALL set pending[i]; pending bits persist until acknowledged.
REQ-014 Priority SHALL be fixed: the lowest index wins.
REQ-015 The FSM SHALL use states IDLE, REQ, ACK and HOLD.
REQ-016 IDLE -> REQ when any pending bit is set and no in_service bit blocks it (see REQ-024).
  - On that transition, latch winner index w and vector = {vector_base[7:3], w[1:0], 1'b0}.
REQ-017 In REQ, int_n SHALL be 0.
  - The latched vector SHALL NOT change until the state returns to IDLE.
REQ-018 REQ -> ACK on the first cycle the synchronized m1_n=0 and iorq_n=0 (INTACK).
  - In the same cycle: clear pending[w], set in_service[w], drive int_n to 1.
REQ-019 data SHALL be driven with the latched vector combinationally whenever raw m1_n=0 and iorq_n=0 and state is REQ or ACK; otherwise data SHALL be Z.
REQ-020 ACK -> HOLD the next cycle; HOLD -> IDLE when synchronized iorq_n=1.
REQ-021 If a new edge on src_req[w] arrives in the same cycle pending[w] is cleared, set SHALL win and pending[w] SHALL remain 1.
REQ-022 Edges on other sources during REQ/ACK/HOLD SHALL only set pending bits and SHALL NOT change the latched vector.
REQ-023 An M1 cycle with iorq_n=1 (opcode fetch) SHALL never cause data to be driven.

Reset
REQ-024 On reset_n=0, immediately and regardless of state:
  - pending, in_service and the synchronizers SHALL clear to 0;
  - the state SHALL go to IDLE;
  - int_n SHALL be 1 and data SHALL be Z.
  - Reset asserted mid-acknowledge SHALL abandon the cycle with no pending bit retained.

Configuration
REQ-025 With RETI_DETECT_EN defined:
  - in_service[w] SHALL stay set after HOLD;
  - IDLE SHALL NOT advance to REQ while any in_service bit is set;
  - in_service SHALL clear when two consecutive synchronized M1 opcode fetches (iorq_n=1) sample data=0xED then 0x4D;
  - any other byte between the two SHALL restart detection.
REQ-026 Without RETI_DETECT_EN, in_service[w] SHALL clear on HOLD -> IDLE and the RETI detector logic SHALL be absent.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the RETI opcode constants 0xED and 0x4D, and the default NUM_SRC.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module, sync2, instantiated once per asynchronous input.

Verification
REQ-029 vector_base=0x40, src_req[2] rises, INTACK issued -> int_n=0 within 3 clks; data=0x44 during INTACK; in_service=0100.
REQ-030 src_req[3] and src_req[1] rise in the same cycle -> first vector 0x42; a second INTACK -> 0x46 (RETI_DETECT_EN off).
REQ-031 Opcode fetch (m1_n=0, iorq_n=1) while in REQ -> data stays Z; int_n stays 0.
REQ-032 RETI_DETECT_EN on, src 0 serviced, src 1 raised -> int_n stays 1 until fetches 0xED, 0x4D; then int_n=0, vector 0x42.
REQ-033 Fetches 0xED, 0x00, 0x4D -> in_service NOT cleared.
REQ-034 reset_n pulsed low during INTACK -> data Z and int_n=1 immediately; pending=0000 after release.
